// File: rtl/dmem_pkg.sv
// Shared decode constants and types for the data-memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_pkg;

  // Byte offsets of the MMIO registers relative to the block base
  localparam logic [31:0] GPIO_OFF = 32'h0000_0000;
  localparam logic [31:0] CNT_OFF  = 32'h0000_0004;
  localparam logic [31:0] STAT_OFF = 32'h0000_0008;

  // Bit positions inside the sticky status register
  localparam int ST_MISALIGN = 0;
  localparam int ST_UNMAPPED = 1;
  localparam int ST_CNT_WRAP = 2;

  // Which target an address selects
  typedef enum logic [2:0] {
    REG_RAM,
    REG_GPIO,
    REG_CNT,
    REG_STAT,
    REG_NONE
  } region_t;

endpackage

// File: rtl/data_memory_responder_ram.sv
// Word-organised data RAM: DEPTH x WIDTH, synchronous write, asynchronous read, no reset.
// Latency: read is combinational; a write becomes visible the cycle after its edge.
// Backpressure: none, every access completes in one cycle.
module ram_array #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 w_en,
  input  logic [ADDR_BITS-1:0] index,
  input  logic [WIDTH-1:0]     w_data,
  output logic [WIDTH-1:0]     r_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Commit store data on the rising edge; contents survive reset
  always_ff @(posedge clock) begin
    if (w_en) mem[index] <= w_data;
  end

  // Read returns the pre-edge contents, so read-during-write yields old data
  assign r_data = mem[index];

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: RAM plus GPIO, free-running counter and sticky W1C status.
// Latency: reads are combinational from ram_address; writes commit on the rising edge.
// Backpressure: none, the core is never stalled.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int                WIDTH     = 32,
  parameter int                DEPTH     = 1024,
  parameter int                ADDR_BITS = $clog2(DEPTH),
  parameter logic [WIDTH-1:0]  MMIO_BASE = WIDTH'(32'h8000_0000)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] ram_address,
  input  logic [WIDTH-1:0] ram_w_data,
  input  logic             read_write_ram_en,
  output logic [WIDTH-1:0] ram_r_data,
  output logic [WIDTH-1:0] gpio_out,
  output logic [2:0]       status_out
);

  localparam logic [WIDTH-1:0] RAM_BYTES = WIDTH'(DEPTH * 4);
  localparam logic [WIDTH-1:0] GPIO_ADDR = MMIO_BASE + WIDTH'(GPIO_OFF);
  localparam logic [WIDTH-1:0] CNT_ADDR  = MMIO_BASE + WIDTH'(CNT_OFF);
  localparam logic [WIDTH-1:0] STAT_ADDR = MMIO_BASE + WIDTH'(STAT_OFF);

  region_t          region;
  logic [WIDTH-1:0] word_addr;
  logic             misaligned;
  logic             ram_we, gpio_we, cnt_we, stat_we;
  logic             misalign_evt, unmapped_evt, wrap_evt;
  logic [WIDTH-1:0] ram_rd;
  logic [WIDTH-1:0] counter;
  logic [2:0]       status;
  logic [2:0]       status_set, status_clr;

  // Byte-lane bits are ignored for region selection; misalignment is judged separately
  assign word_addr  = {ram_address[WIDTH-1:2], 2'b00};
  assign misaligned = (ram_address[1:0] != 2'b00);

  // Region decode; the RAM test uses the whole address so aliases above the RAM are unmapped
  always_comb begin
    region = REG_NONE;
    if (ram_address < RAM_BYTES)     region = REG_RAM;
    else if (word_addr == GPIO_ADDR) region = REG_GPIO;
    else if (word_addr == CNT_ADDR)  region = REG_CNT;
    else if (word_addr == STAT_ADDR) region = REG_STAT;
  end

  // Misaligned stores are dropped everywhere and only raise a status flag
  assign ram_we       = read_write_ram_en && !misaligned && (region == REG_RAM);
  assign gpio_we      = read_write_ram_en && !misaligned && (region == REG_GPIO);
  assign cnt_we       = read_write_ram_en && !misaligned && (region == REG_CNT);
  assign stat_we      = read_write_ram_en && !misaligned && (region == REG_STAT);
  assign misalign_evt = read_write_ram_en && misaligned;
  assign unmapped_evt = read_write_ram_en && !misaligned && (region == REG_NONE);
  // A counter load overrides the increment, so it can never wrap on that edge
  assign wrap_evt     = (counter == '1) && !cnt_we;

  ram_array #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clock  (clock),
    .w_en   (ram_we),
    .index  (ram_address[ADDR_BITS+1:2]),
    .w_data (ram_w_data),
    .r_data (ram_rd)
  );

  // GPIO output register
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        gpio_out <= '0;
    else if (gpio_we) gpio_out <= ram_w_data;
  end

  // Free-running cycle counter with write-to-load
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       counter <= '0;
    else if (cnt_we) counter <= ram_w_data;
    else             counter <= counter + 1'b1;
  end

  always_comb begin
    status_set              = '0;
    status_set[ST_MISALIGN] = misalign_evt;
    status_set[ST_UNMAPPED] = unmapped_evt;
    status_set[ST_CNT_WRAP] = wrap_evt;
    status_clr              = stat_we ? ram_w_data[2:0] : 3'b000;
  end

  // Sticky status: clear first, then set, so a coinciding set event wins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) status <= '0;
    else       status <= (status & ~status_clr) | status_set;
  end

  assign status_out = status;

  // Whole-word read mux; unmapped addresses read as zero
  always_comb begin
    ram_r_data = '0;
    case (region)
      REG_RAM:  ram_r_data = ram_rd;
      REG_GPIO: ram_r_data = gpio_out;
      REG_CNT:  ram_r_data = counter;
      REG_STAT: ram_r_data = {{(WIDTH-3){1'b0}}, status};
      default:  ram_r_data = '0;
    endcase
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: RAM, MMIO registers, status and async reset.
// Latency: inputs driven on the falling edge, outputs sampled before the next rising edge.
// Backpressure: n/a.
module tb_data_memory_responder;

  localparam logic [31:0] A_GPIO = 32'h8000_0000;
  localparam logic [31:0] A_CNT  = 32'h8000_0004;
  localparam logic [31:0] A_STAT = 32'h8000_0008;

  logic        clock;
  logic        reset;
  logic [31:0] ram_address;
  logic [31:0] ram_w_data;
  logic        read_write_ram_en;
  logic [31:0] ram_r_data;
  logic [31:0] gpio_out;
  logic [2:0]  status_out;

  int total = 0;
  int bad   = 0;

  data_memory_responder dut (
    .clock             (clock),
    .reset             (reset),
    .ram_address       (ram_address),
    .ram_w_data        (ram_w_data),
    .read_write_ram_en (read_write_ram_en),
    .ram_r_data        (ram_r_data),
    .gpio_out          (gpio_out),
    .status_out        (status_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One store: drive on a falling edge, commit on the following rising edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    ram_address       = a;
    ram_w_data        = d;
    read_write_ram_en = 1'b1;
    @(negedge clock);
    read_write_ram_en = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    total++; if (gpio_out !== 32'h0) begin bad++; $display("FAIL reset_gpio got=%h exp=%h", gpio_out, 32'h0); end
    total++; if (status_out !== 3'b000) begin bad++; $display("FAIL reset_status got=%b exp=%b", status_out, 3'b000); end
    ram_address = A_CNT; #1;
    total++; if (ram_r_data !== 32'h0) begin bad++; $display("FAIL reset_cnt_read got=%h exp=%h", ram_r_data, 32'h0); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_ram_write;
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    ram_address = 32'h0000_0010; #1;
    total++; if (ram_r_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_rd_10 got=%h exp=%h", ram_r_data, 32'hDEAD_BEEF); end
    ram_address = 32'h0000_0013; #1;
    total++; if (ram_r_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_rd_13 got=%h exp=%h", ram_r_data, 32'hDEAD_BEEF); end
    // Just past the RAM must not alias onto word 0
    ram_address = 32'h0000_1000; #1;
    total++; if (ram_r_data !== 32'h0) begin bad++; $display("FAIL ram_alias_1000 got=%h exp=%h", ram_r_data, 32'h0); end
    wr(32'h0000_0FFC, 32'h0BAD_F00D);
    ram_address = 32'h0000_0FFC; #1;
    total++; if (ram_r_data !== 32'h0BAD_F00D) begin bad++; $display("FAIL ram_last_word got=%h exp=%h", ram_r_data, 32'h0BAD_F00D); end
  endtask

  task automatic test_read_during_write;
    wr(32'h0000_0020, 32'hAAAA_AAAA);
    @(negedge clock);
    ram_address       = 32'h0000_0020;
    ram_w_data        = 32'h1234_5678;
    read_write_ram_en = 1'b1;
    #1;
    total++; if (ram_r_data !== 32'hAAAA_AAAA) begin bad++; $display("FAIL rdw_old got=%h exp=%h", ram_r_data, 32'hAAAA_AAAA); end
    @(negedge clock);
    read_write_ram_en = 1'b0;
    #1;
    total++; if (ram_r_data !== 32'h1234_5678) begin bad++; $display("FAIL rdw_new got=%h exp=%h", ram_r_data, 32'h1234_5678); end
  endtask

  task automatic test_misaligned;
    wr(32'h0000_0022, 32'h0000_FFFF);
    ram_address = 32'h0000_0020; #1;
    total++; if (ram_r_data !== 32'h1234_5678) begin bad++; $display("FAIL misalign_ram got=%h exp=%h", ram_r_data, 32'h1234_5678); end
    total++; if (status_out !== 3'b001) begin bad++; $display("FAIL misalign_status got=%b exp=%b", status_out, 3'b001); end
    ram_address = A_STAT; #1;
    total++; if (ram_r_data !== 32'h1) begin bad++; $display("FAIL status_read got=%h exp=%h", ram_r_data, 32'h1); end
    wr(A_STAT, 32'h0000_0001);
    total++; if (status_out !== 3'b000) begin bad++; $display("FAIL w1c_clear got=%b exp=%b", status_out, 3'b000); end
  endtask

  task automatic test_counter_wrap;
    // Load edge: no increment and no wrap
    wr(A_CNT, 32'hFFFF_FFFE);
    ram_address = A_CNT; #1;
    total++; if (ram_r_data !== 32'hFFFF_FFFE) begin bad++; $display("FAIL cnt_load got=%h exp=%h", ram_r_data, 32'hFFFF_FFFE); end
    total++; if (status_out !== 3'b000) begin bad++; $display("FAIL cnt_no_wrap got=%b exp=%b", status_out, 3'b000); end
    @(negedge clock); #1;
    total++; if (ram_r_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cnt_max got=%h exp=%h", ram_r_data, 32'hFFFF_FFFF); end
    // Clear bit 2 on the very edge the counter wraps: the set must win
    ram_address       = A_STAT;
    ram_w_data        = 32'h0000_0004;
    read_write_ram_en = 1'b1;
    @(negedge clock);
    read_write_ram_en = 1'b0;
    ram_address       = A_CNT;
    #1;
    total++; if (ram_r_data !== 32'h0) begin bad++; $display("FAIL cnt_wrap_zero got=%h exp=%h", ram_r_data, 32'h0); end
    total++; if (status_out !== 3'b100) begin bad++; $display("FAIL wrap_set_wins got=%b exp=%b", status_out, 3'b100); end
    @(negedge clock); #1;
    total++; if (ram_r_data !== 32'h1) begin bad++; $display("FAIL cnt_after_wrap got=%h exp=%h", ram_r_data, 32'h1); end
    wr(A_STAT, 32'h0000_0004);
    total++; if (status_out !== 3'b000) begin bad++; $display("FAIL wrap_clear got=%b exp=%b", status_out, 3'b000); end
  endtask

  task automatic test_gpio_unmapped;
    wr(A_GPIO, 32'h0000_005A);
    wr(32'h4000_0000, 32'h0000_0001);
    ram_address = 32'h4000_0000; #1;
    total++; if (ram_r_data !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=%h", ram_r_data, 32'h0); end
    total++; if (gpio_out !== 32'h0000_005A) begin bad++; $display("FAIL gpio_out got=%h exp=%h", gpio_out, 32'h5A); end
    total++; if (status_out !== 3'b010) begin bad++; $display("FAIL unmapped_status got=%b exp=%b", status_out, 3'b010); end
    ram_address = A_GPIO; #1;
    total++; if (ram_r_data !== 32'h0000_005A) begin bad++; $display("FAIL gpio_read got=%h exp=%h", ram_r_data, 32'h5A); end
  endtask

  task automatic test_async_reset;
    @(negedge clock);
    ram_address       = A_GPIO;
    ram_w_data        = 32'h0000_0077;
    read_write_ram_en = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    total++; if (gpio_out !== 32'h0) begin bad++; $display("FAIL async_gpio got=%h exp=%h", gpio_out, 32'h0); end
    total++; if (status_out !== 3'b000) begin bad++; $display("FAIL async_status got=%b exp=%b", status_out, 3'b000); end
    read_write_ram_en = 1'b0;
    ram_address       = A_CNT;
    #1;
    total++; if (ram_r_data !== 32'h0) begin bad++; $display("FAIL async_cnt got=%h exp=%h", ram_r_data, 32'h0); end
    ram_address = 32'h0000_0010;
    #0.5;
    total++; if (ram_r_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_retained got=%h exp=%h", ram_r_data, 32'hDEAD_BEEF); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock); #1;
    total++; if (gpio_out !== 32'h0) begin bad++; $display("FAIL gpio_after_reset got=%h exp=%h", gpio_out, 32'h0); end
  endtask

  initial begin
    reset             = 1'b1;
    ram_address       = 32'h0;
    ram_w_data        = 32'h0;
    read_write_ram_en = 1'b0;
    test_reset();
    test_ram_write();
    test_read_during_write();
    test_misaligned();
    test_counter_wrap();
    test_gpio_unmapped();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
